// File: rtl/branch_metric.sv
`default_nettype none
// ============================================================================
// Module   : branch_metric
// Brief    : Turbo/BCJR branch metric unit. Emits forward metrics as triples
//            arrive and replays them in reverse order from a block buffer.
// Revision : 1.0
// ============================================================================
module branch_metric #(
    parameter int MAX_LEN = 6144,
    parameter int AW      = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       blk_len,
    input  logic signed [7:0]   sys_llr,
    input  logic signed [7:0]   par_llr,
    input  logic signed [7:0]   apr_llr,
    input  logic                valid_in,
    output logic                ready_in,
    output logic signed [15:0]  init_branch1,
    output logic signed [15:0]  init_branch2,
    output logic                valid_branch,
    output logic signed [15:0]  rev_branch1,
    output logic signed [15:0]  rev_branch2,
    output logic                valid_rev,
    output logic                last_rev,
    output logic [1:0]          fsm_state,
    output logic                done,
    output logic                len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FWD  = 2'b01,
        S_BWD  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [AW:0] c_max_len = (AW+1)'(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_wr_cnt;
    logic [AW-1:0]      r_rd_cnt;
    // FWD: the gap cycle after an acceptance; BWD: the cycle read data returns
    logic               r_phase;
    logic               r_valid_branch;
    logic               r_valid_rev;
    logic               r_last_rev;
    logic               r_len_err;
    logic signed [15:0] r_init1;
    logic signed [15:0] r_init2;
    logic [31:0]        r_rd_word;
    logic [31:0]        r_mem [0:MAX_LEN-1];

    logic               w_len_ok;
    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_accept;
    logic               w_rd_en;
    logic signed [15:0] w_br1;
    logic signed [15:0] w_br2;
    logic [AW-1:0]      w_addr;

    assign w_len_ok = (blk_len != '0) && ({1'b0, blk_len} <= c_max_len);

    always_comb begin
        w_br1 = {{8{sys_llr[7]}}, sys_llr} + {{8{apr_llr[7]}}, apr_llr}
              + {{8{par_llr[7]}}, par_llr};
        w_br2 = {{8{sys_llr[7]}}, sys_llr} + {{8{apr_llr[7]}}, apr_llr}
              - {{8{par_llr[7]}}, par_llr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        ready_in    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_FWD;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            S_FWD: begin
                ready_in = ~r_phase;
                if (!r_phase) begin
                    w_accept = valid_in;
                end else if (r_wr_cnt == r_len) begin
                    w_state_nxt = S_BWD;
                end
            end
            S_BWD: begin
                if (!r_phase) begin
                    w_rd_en = 1'b1;
                end else if (r_rd_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len          <= '0;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_phase        <= 1'b0;
            r_valid_branch <= 1'b0;
            r_valid_rev    <= 1'b0;
            r_last_rev     <= 1'b0;
            r_len_err      <= 1'b0;
            r_init1        <= '0;
            r_init2        <= '0;
        end else begin
            r_phase        <= w_accept | w_rd_en;
            r_valid_branch <= w_accept;
            r_valid_rev    <= w_rd_en;
            r_last_rev     <= w_rd_en && (r_rd_cnt == '0);
            r_len_err      <= w_start_bad;
            if (w_start_ok) begin
                r_len    <= blk_len;
                r_wr_cnt <= '0;
            end
            if (w_accept) begin
                r_init1  <= w_br1;
                r_init2  <= w_br2;
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end
            if (r_state == S_FWD && w_state_nxt == S_BWD) begin
                r_rd_cnt <= r_len - AW'(1);
            end else if (r_state == S_BWD && r_phase) begin
                r_rd_cnt <= r_rd_cnt - AW'(1);
            end
        end
    end

    // Single-port buffer: writes happen only in FWD, reads only in BWD
    assign w_addr = w_accept ? r_wr_cnt : r_rd_cnt;

    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mem[w_addr] <= {w_br1, w_br2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_word <= '0;
        end else if (w_rd_en) begin
            r_rd_word <= r_mem[w_addr];
        end
    end

    assign init_branch1 = r_init1;
    assign init_branch2 = r_init2;
    assign valid_branch = r_valid_branch;
    assign rev_branch1  = r_rd_word[31:16];
    assign rev_branch2  = r_rd_word[15:0];
    assign valid_rev    = r_valid_rev;
    assign last_rev     = r_last_rev;
    assign len_err      = r_len_err;
    assign fsm_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_branch_metric.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_metric
// Brief    : Scoreboard bench for branch_metric: forward/reverse streams,
//            reverse timing, length errors and mid-block reset.
// Revision : 1.0
// ============================================================================
module tb_branch_metric;

    localparam int MAX_LEN = 6144;
    localparam int AW      = 13;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [AW-1:0]      blk_len = '0;
    logic signed [7:0]  sys_llr = '0;
    logic signed [7:0]  par_llr = '0;
    logic signed [7:0]  apr_llr = '0;
    logic               valid_in = 1'b0;
    logic               ready_in;
    logic signed [15:0] init_branch1, init_branch2, rev_branch1, rev_branch2;
    logic               valid_branch, valid_rev, last_rev, done, len_err;
    logic [1:0]         fsm_state;

    branch_metric #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .blk_len(blk_len),
        .sys_llr(sys_llr), .par_llr(par_llr), .apr_llr(apr_llr),
        .valid_in(valid_in), .ready_in(ready_in),
        .init_branch1(init_branch1), .init_branch2(init_branch2),
        .valid_branch(valid_branch),
        .rev_branch1(rev_branch1), .rev_branch2(rev_branch2),
        .valid_rev(valid_rev), .last_rev(last_rev),
        .fsm_state(fsm_state), .done(done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b1;
        logic [15:0] b2;
        logic        last;
        int          off;
    } exp_t;

    exp_t fwd_q[$];
    exp_t rev_q[$];
    int   s_q[$], p_q[$], a_q[$], b1_q[$], b2_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   e_cyc    = 0;
    logic [1:0] prev_state = 2'b00;
    logic prev_vb = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a metric
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (fsm_state == 2'b10 && prev_state != 2'b10) e_cyc = cyc;
        prev_state = fsm_state;
        if (valid_branch === 1'b1) begin
            chk("fwd_not_consecutive", {31'b0, prev_vb}, 32'd0);
            if (fwd_q.size() == 0) begin
                chk("fwd_unexpected", 32'd1, 32'd0);
            end else begin
                e = fwd_q.pop_front();
                chk("fwd_br1", {16'b0, init_branch1}, {16'b0, e.b1});
                chk("fwd_br2", {16'b0, init_branch2}, {16'b0, e.b2});
            end
        end
        prev_vb = (valid_branch === 1'b1);
        if (valid_rev === 1'b1) begin
            if (rev_q.size() == 0) begin
                chk("rev_unexpected", 32'd1, 32'd0);
            end else begin
                e = rev_q.pop_front();
                chk("rev_br1", {16'b0, rev_branch1}, {16'b0, e.b1});
                chk("rev_br2", {16'b0, rev_branch2}, {16'b0, e.b2});
                chk("rev_last", {31'b0, last_rev}, {31'b0, e.last});
                chk("rev_timing", cyc - e_cyc, e.off);
            end
        end else if (last_rev === 1'b1) begin
            chk("last_without_valid", 32'd1, 32'd0);
        end
    end

    task automatic clear_vec();
        s_q.delete(); p_q.delete(); a_q.delete(); b1_q.delete(); b2_q.delete();
    endtask

    task automatic add_vec(input int s, input int p, input int a, input int b1, input int b2);
        s_q.push_back(s); p_q.push_back(p); a_q.push_back(a);
        b1_q.push_back(b1); b2_q.push_back(b2);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {24'b0, ready_in, valid_branch, valid_rev, last_rev,
                           done, len_err, fsm_state}, 32'd0);
        chk({nm, "_init"}, {init_branch1, init_branch2}, 32'd0);
        chk({nm, "_rev"}, {rev_branch1, rev_branch2}, 32'd0);
    endtask

    // Queues expectations, starts the block and feeds all K triples
    task automatic run_block(input int k, input bit poke);
        exp_t e;
        int   idx;
        int   guard;
        bit   prev_acc;
        for (int i = 0; i < k; i++) begin
            e.b1 = 16'(b1_q[i]); e.b2 = 16'(b2_q[i]); e.last = 1'b0; e.off = 0;
            fwd_q.push_back(e);
        end
        for (int i = k - 1; i >= 0; i--) begin
            e.b1 = 16'(b1_q[i]); e.b2 = 16'(b2_q[i]);
            e.last = (i == 0); e.off = 2 * (k - 1 - i) + 1;
            rev_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1; blk_len = AW'(k);
        @(negedge clk);
        start = 1'b0;
        chk("enter_fwd", {30'b0, fsm_state}, 32'd1);
        idx = 0; guard = 0; prev_acc = 1'b0;
        while (idx < k) begin
            if (guard > 4 * k + 16) begin
                chk("drive_timeout", 32'd1, 32'd0);
                break;
            end
            if (prev_acc) chk("ready_alternates", {31'b0, ready_in}, 32'd0);
            valid_in = 1'b1;
            if (ready_in === 1'b1) begin
                sys_llr = 8'(s_q[idx]); par_llr = 8'(p_q[idx]); apr_llr = 8'(a_q[idx]);
                idx++;
                prev_acc = 1'b1;
            end else begin
                sys_llr = 8'sh55; par_llr = -8'sd77; apr_llr = 8'sh33;
                prev_acc = 1'b0;
            end
            if (poke && idx == 1 && prev_acc) begin
                start = 1'b1; blk_len = AW'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        valid_in = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done !== 1'b1 && g < 2 * MAX_LEN + 64) begin
            @(negedge clk);
            g++;
        end
        if (done === 1'b1) begin
            chk("done_state", {30'b0, fsm_state}, 32'd3);
            chk("done_queues_empty", fwd_q.size() + rev_q.size(), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {29'b0, done, fsm_state}, 32'd0);
        end else begin
            chk("done_timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        int g;
        int s, p, a;
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Rejected starts: length 0 and MAX_LEN+1
        start = 1'b1; blk_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("len_err_zero", {29'b0, len_err, fsm_state}, 32'h4);
        @(negedge clk);
        chk("len_err_pulse_zero", {31'b0, len_err}, 32'd0);
        start = 1'b1; blk_len = AW'(MAX_LEN + 1);
        @(negedge clk);
        start = 1'b0;
        chk("len_err_over", {29'b0, len_err, fsm_state}, 32'h4);
        @(negedge clk);
        chk("len_err_pulse_over", {31'b0, len_err}, 32'd0);

        // K=1, sys=10 par=3 apr=-2
        clear_vec();
        add_vec(10, 3, -2, 11, 5);
        run_block(1, 1'b0);
        wait_done();

        // K=1, all inputs at -128
        clear_vec();
        add_vec(-128, -128, -128, 32'hFE80, 32'hFF80);
        run_block(1, 1'b0);
        wait_done();

        // K=4 ramp with a start pulse mid-FWD that must be ignored
        clear_vec();
        for (int i = 0; i < 4; i++) add_vec(i, 0, 0, i, i);
        run_block(4, 1'b1);
        wait_done();

        // K=8, reset mid-BWD
        clear_vec();
        for (int i = 0; i < 8; i++) add_vec(3 * i - 9, 20 - i, i, 3 * i - 9 + i + 20 - i, 3 * i - 9 + i - 20 + i);
        run_block(8, 1'b0);
        g = 0;
        while (fsm_state !== 2'b10 && g < 64) begin
            @(negedge clk);
            g++;
        end
        chk("reached_bwd", {30'b0, fsm_state}, 32'd2);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        fwd_q.delete();
        rev_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_bwd_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {29'b0, valid_rev, fsm_state}, 32'd0);

        // Fresh K=2 block after the reset
        clear_vec();
        add_vec(5, -7, 1, 32'hFFFF, 13);
        add_vec(-20, 4, -100, 32'hFF8C, 32'hFF84);
        run_block(2, 1'b0);
        wait_done();

        // K=MAX_LEN random LLRs against the metric equations
        clear_vec();
        for (int i = 0; i < MAX_LEN; i++) begin
            s = int'($urandom_range(255)) - 128;
            p = int'($urandom_range(255)) - 128;
            a = int'($urandom_range(255)) - 128;
            add_vec(s, p, a, s + a + p, s + a - p);
        end
        run_block(MAX_LEN, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_metric.md
BRANCH_METRIC -- requirements
Module: branch_metric

Interface
REQ-001 Parameter MAX_LEN, default 6144, maximum trellis steps per block.
REQ-002 Parameter AW, default 13, buffer address width; SHALL satisfy 2**AW >= MAX_LEN.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a block.
REQ-006 blk_len  input  AW  number of trellis steps K, sampled with start.
REQ-007 sys_llr  input  8  signed systematic channel LLR.
REQ-008 par_llr  input  8  signed parity channel LLR.
REQ-009 apr_llr  input  8  signed a-priori LLR.
REQ-010 valid_in  input  1  LLR triple valid.
REQ-011 ready_in  output  1  triple accepted when valid_in && ready_in.
REQ-012 init_branch1  output  16  signed forward branch metric, feeds the alpha recursion.
REQ-013 init_branch2  output  16  signed forward branch metric, feeds the alpha recursion.
REQ-014 valid_branch  output  1  forward metrics valid.
REQ-015 rev_branch1, rev_branch2  output  16 each  signed metrics in reverse order for the beta recursion.
REQ-016 valid_rev  output  1  reverse metrics valid.
REQ-017 last_rev  output  1  marks the reverse word for step 0.
REQ-018 fsm_state  output  2  00 IDLE, 01 FWD, 10 BWD, 11 DONE; drives the recursion units' clear.
REQ-019 done  output  1  one-cycle end-of-block pulse.
REQ-020 len_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-021 Metrics: br1 = sext16(sys)+sext16(apr)+sext16(par); br2 = sext16(sys)+sext16(apr)-sext16(par); no scaling; range ±384, so no saturation.
REQ-022 IDLE: on start with 1 <= blk_len <= MAX_LEN, latch K, clear wr_cnt and phase, and go to FWD next cycle.
REQ-023 IDLE: on start with blk_len == 0 or blk_len > MAX_LEN, pulse len_err next cycle and remain in IDLE.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 FWD: ready_in = (phase == 0).
REQ-026 FWD acceptance at cycle t: register br1/br2 to init_branch1/2 with valid_branch = 1 at t+1, write {br1, br2} to buffer[wr_cnt], increment wr_cnt, and set phase = 1.
REQ-027 phase SHALL return to 0 one cycle after being set; valid_branch is therefore never high on two consecutive cycles, as the alpha stage requires (it computes on valid cycles and commits on non-valid cycles).
REQ-028 valid_in while ready_in = 0 SHALL be ignored and not stored.
REQ-029 On acceptance of the K-th triple, go to BWD on the cycle after the final valid_branch.
REQ-030 BWD: read buffer index K-1 down to 0, one read every 2 cycles, with one-cycle read latency.
REQ-031 BWD output timing: with E = first BWD cycle, word i SHALL appear on rev_branch1/2 with valid_rev = 1 at cycle E+1+2*(K-1-i).
REQ-032 last_rev = 1 only with word 0.
REQ-033 After word 0, go to DONE for exactly one cycle with done = 1, then IDLE.
REQ-034 init_branch1/2 and rev_branch1/2 SHALL hold their last value when their valid is low.
REQ-035 valid_branch, valid_rev, last_rev, done, and len_err SHALL be 0 whenever their condition does not hold.
REQ-036 ready_in = 0 outside FWD.
REQ-037 Buffer is single-port, depth MAX_LEN, width 32, and is not cleared by reset.
REQ-038 K = 1: one forward word, then one reverse word with last_rev = 1, then DONE.

Reset
REQ-039 rst SHALL take priority over all inputs, including mid-FWD or mid-BWD.
REQ-040 Next-cycle reset values: fsm_state = 00; ready_in, valid_branch, valid_rev, last_rev, done, len_err = 0; init_branch1/2, rev_branch1/2 = 0; counters and phase = 0.
REQ-041 After reset, the partially processed block SHALL be discarded; a new start is required.

Verification
REQ-042 K=1; sys=10, par=3, apr=-2 -> init_branch1=11, init_branch2=5, valid_branch one cycle; then rev 11/5 with last_rev=1; then done.
REQ-043 K=1; sys=par=apr=-128 -> init_branch1=16'hFE80 (-384), init_branch2=16'hFF80 (-128).
REQ-044 K=4; valid_in held high with sys=0..3, par=0, apr=0 -> ready_in alternates 1/0; forward br1=0,1,2,3; reverse br1=3,2,1,0 on cycles E+1, E+3, E+5, E+7; last_rev on the last.
REQ-045 start with blk_len=0 and with blk_len=MAX_LEN+1 -> len_err pulse, fsm_state stays 00; start during FWD -> ignored.
REQ-046 rst asserted mid-BWD of a K=8 block -> all outputs at reset values next cycle; a fresh K=2 block then completes correctly.
REQ-047 K=MAX_LEN random LLRs -> forward and reverse streams match a reference model, and valid_branch is never high on consecutive cycles.
